instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 98 +++++++++
 tb/tb_instr_fetch_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: PC sequencer with jump/branch redirect feeding a small instruction FIFO
module instr_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter bit BR_ON_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_pc,
  input  logic [ADDR_W-1:0]        rs_pc,
  input  logic                     Branch,
  input  logic                     zero,
  input  logic                     jr,
  input  logic                     jl,
  input  logic [15:0]              Imm16,
  input  logic [25:0]              TargetAddr,
  input  logic [ADDR_W-1:0]        Da,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] START = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  localparam logic [1:0] REDIR = 2'd3;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]       instr_q [DEPTH];
  logic [31:0]       instr_d [DEPTH];
  logic [ADDR_W-1:0] pcs_q [DEPTH];
  logic [ADDR_W-1:0] pcs_d [DEPTH];
  logic              redirect, room, push, pop, has;
  logic [ADDR_W-1:0] jl_tgt, br_tgt, target;
  always_comb begin
    redirect = reset_n & (jl | jr | (Branch & (zero == BR_ON_ZERO)));
    jl_tgt = (rs_pc & ~ADDR_W'(28'hfff_ffff)) | ADDR_W'({TargetAddr, 2'b00});
    br_tgt = rs_pc + ADDR_W'(4) + {{(ADDR_W-18){Imm16[15]}}, Imm16, 2'b00};
    target = jl ? jl_tgt : jr ? (Da & ~ADDR_W'(3)) : br_tgt;
    room = (count_q + CW'(inflight_q)) < CW'(DEPTH);
    imem_addr = fetch_pc_q & ~ADDR_W'(3);
    // requests are held off in a redirect cycle so nothing stale lands in the flushed queue
    imem_req = reset_n & ~redirect & (state_q == FETCH) & room;
    push = inflight_q & ~redirect;
    has = reset_n && count_q != '0;
    out_valid = has & ~redirect;
    pop = out_valid & out_ready;
    out_instr = has ? instr_q[rd_ptr_q] : '0;
    out_pc = has ? pcs_q[rd_ptr_q] : '0;
    count = count_q;
    state_d = redirect ? REDIR : (state_q == START || state_q == REDIR) ? FETCH : room ? FETCH : FULL;
    fetch_pc_d = redirect ? target : imem_req ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
    inflight_d = imem_req;
    inflight_pc_d = imem_addr;
    wr_ptr_d = redirect ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = redirect ? '0 : rd_ptr_q + PW'(pop);
    count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    instr_d = instr_q;
    pcs_d = pcs_q;
    if (push) begin
      instr_d[wr_ptr_q] = imem_rdata;
      pcs_d[wr_ptr_q] = inflight_pc_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= START;
      fetch_pc_q <= RESET_PC;
      count_q <= '0;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pcs_q <= pcs_d;
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed redirect/backpressure scenarios with a scoreboard-checked output stream
module tb_instr_fetch_queue;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] rs_pc = '0;
  logic        Branch = 1'b0, zero = 1'b0, jr = 1'b0, jl = 1'b0;
  logic [15:0] Imm16 = '0;
  logic [25:0] TargetAddr = '0;
  logic [31:0] Da = '0;
  logic [2:0]  count;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  instr_fetch_queue dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .rs_pc(rs_pc), .Branch(Branch),
    .zero(zero), .jr(jr), .jl(jl), .Imm16(Imm16), .TargetAddr(TargetAddr),
    .Da(Da), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) imem_rdata <= imem_req ? mem_f(imem_addr) : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %h want none", out_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_out_pc", out_pc, e);
        check("sb_out_instr", out_instr, mem_f(e));
      end
    end
  end

  initial begin
    jl = 1'b1;
    Branch = 1'b1;
    zero = 1'b1;
    repeat (3) tick();
    check("rst_req", imem_req, 0);
    check("rst_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    jl = 1'b0;
    Branch = 1'b0;
    zero = 1'b0;
    reset_n = 1'b1;
    check("start_noreq", imem_req, 0);
    tick();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
    tick();
    check("second_addr", imem_addr, 32'h4);
    repeat (6) tick();
    check("full_count", count, 4);
    check("full_noreq", imem_req, 0);
    check("full_head_pc", out_pc, 32'h0);
    check("full_valid", out_valid, 1);
    check("full_head_instr", out_instr, mem_f(32'h0));
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    out_ready = 1'b1;
    repeat (2) tick();
    check("resume_addr", imem_addr, 32'h10);
    check("resume_req", imem_req, 1);
    repeat (3) tick();
    check("stream_addr", imem_addr, 32'h1C);
    repeat (5) tick();
    out_ready = 1'b0;
    repeat (5) tick();
    check("refill_count", count, 4);
    check("refill_head", out_pc, 32'h28);
    Branch = 1'b1;
    zero = 1'b1;
    rs_pc = 32'h100;
    Imm16 = 16'hFFFE;
    out_ready = 1'b1;
    #1;
    check("br_valid_low", out_valid, 0);
    tick();
    Branch = 1'b0;
    zero = 1'b0;
    out_ready = 1'b0;
    check("br_flush", count, 0);
    check("br_bubble", imem_req, 0);
    tick();
    check("br_req", imem_req, 1);
    check("br_target", imem_addr, 32'h0FC);
    Branch = 1'b1;
    #1;
    check("br_nt_addr", imem_addr, 32'h0FC);
    tick();
    Branch = 1'b0;
    check("br_seq", imem_addr, 32'h100);
    repeat (5) tick();
    check("br_full", count, 4);
    check("br_head", out_pc, 32'h0FC);
    exp_q.push_back(32'h0FC);
    exp_q.push_back(32'h100);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    repeat (5) tick();
    check("pop2_full", count, 4);
    check("pop2_head", out_pc, 32'h104);
    jl = 1'b1;
    jr = 1'b1;
    Branch = 1'b1;
    zero = 1'b1;
    rs_pc = 32'hA000_0000;
    TargetAddr = 26'h10;
    Da = 32'h1234_5678;
    Imm16 = 16'h0;
    #1;
    check("jl_valid_low", out_valid, 0);
    tick();
    jl = 1'b0;
    jr = 1'b0;
    Branch = 1'b0;
    zero = 1'b0;
    check("jl_flush", count, 0);
    tick();
    check("jl_target", imem_addr, 32'hA000_0040);
    tick();
    jr = 1'b1;
    Da = 32'h0000_0207;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h204 + 32'(i * 4));
    tick();
    jr = 1'b0;
    tick();
    check("jr_req", imem_req, 1);
    check("jr_target", imem_addr, 32'h204);
    repeat (7) tick();
    jr = 1'b1;
    Da = 32'hFFFF_FFFC;
    #1;
    check("jr2_valid_low", out_valid, 0);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    tick();
    jr = 1'b0;
    check("jr2_flush", count, 0);
    tick();
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_zero", imem_addr, 32'h0);
    repeat (4) tick();
    out_ready = 1'b0;
    repeat (5) tick();
    check("wrap_full", count, 4);
    check("wrap_head", out_pc, 32'h8);
    reset_n = 1'b0;
    tick();
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_pc", out_pc, 0);
    reset_n = 1'b1;
    tick();
    check("rerun_req", imem_req, 1);
    check("rerun_addr", imem_addr, 32'h0);
    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
